// File: rtl/hd_loader.sv
// Disk <-> memory block copy engine: LOAD streams disk words into a process region,
// STORE streams a region back to disk, one word per cycle with a one-cycle read latency.
module hd_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int MAX_PROC_NUM = 16,
  parameter int REGION       = (2**ADDR_WIDTH)/MAX_PROC_NUM,
  parameter int DISK_SIZE    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dir,
  input  logic [3:0]            proc_id,
  input  logic [DATA_WIDTH-1:0] disk_base,
  input  logic [11:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] hd_address,
  output logic                  hd_write_flag,
  output logic [DATA_WIDTH-1:0] hd_wdata,
  input  logic [DATA_WIDTH-1:0] hd_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, FIN} state_t;

  state_t                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [ADDR_WIDTH-1:0] mbase_q, mbase_d, start_mbase;
  logic [DATA_WIDTH-1:0] dbase_q, dbase_d;
  logic [11:0]           len_q, len_d, cnt_q, cnt_d, nxt;
  logic                  more, oob;
  logic [DATA_WIDTH:0]   end_addr;
  logic                  busy_d, done_d, err_d, hd_wf_d, mem_we_d;
  logic [DATA_WIDTH-1:0] hd_addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  assign start_mbase = ADDR_WIDTH'(proc_id) * ADDR_WIDTH'(REGION);
  assign end_addr    = {1'b0, disk_base} + (DATA_WIDTH+1)'(length);
  assign oob         = (length > 12'(REGION)) || (end_addr > (DATA_WIDTH+1)'(DISK_SIZE));
  assign nxt         = cnt_q + 12'd1;
  assign more        = nxt < len_q;

  // Write data is the read port passed straight through in the write slot, since
  // read data only becomes valid in that same cycle.
  assign mem_wdata = mem_we        ? hd_rdata  : '0;
  assign hd_wdata  = hd_write_flag ? mem_rdata : '0;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    mbase_d    = mbase_q;
    dbase_d    = dbase_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = 1'b0;
    hd_wf_d    = 1'b0;
    mem_we_d   = 1'b0;
    hd_addr_d  = '0;
    mem_addr_d = '0;
    case (state_q)
      IDLE: if (start) begin
        dir_d   = dir;
        mbase_d = start_mbase;
        dbase_d = disk_base;
        len_d   = length;
        cnt_d   = '0;
        if (oob) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (length == '0) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          busy_d  = 1'b1;
          state_d = XFER;
          if (dir) mem_addr_d = start_mbase;
          else     hd_addr_d  = disk_base;
        end
      end
      // Each edge retires the word issued this cycle and issues the next one.
      XFER: begin
        if (dir_q) begin
          hd_wf_d   = 1'b1;
          hd_addr_d = dbase_q + DATA_WIDTH'(cnt_q);
          if (more) mem_addr_d = mbase_q + ADDR_WIDTH'(nxt);
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = mbase_q + ADDR_WIDTH'(cnt_q);
          if (more) hd_addr_d = dbase_q + DATA_WIDTH'(nxt);
        end
        if (more) cnt_d   = nxt;
        else      state_d = DRAIN;
      end
      DRAIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dir_q         <= 1'b0;
      mbase_q       <= '0;
      dbase_q       <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      hd_address    <= '0;
      hd_write_flag <= 1'b0;
      mem_address   <= '0;
      mem_we        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      mbase_q       <= mbase_d;
      dbase_q       <= dbase_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
      hd_address    <= hd_addr_d;
      hd_write_flag <= hd_wf_d;
      mem_address   <= mem_addr_d;
      mem_we        <= mem_we_d;
    end
  end
endmodule

// File: tb/tb_hd_loader.sv
// Scoreboard bench for hd_loader: commands push the expected write/done/err events
// (with their cycle) into a queue; a negedge monitor pops and compares them.
module tb_hd_loader;
  localparam int K_MW = 0, K_HW = 1, K_DONE = 2, K_ERR = 3;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, dir = 1'b0;
  logic [3:0]  proc_id = '0;
  logic [31:0] disk_base = '0;
  logic [11:0] length = '0;
  logic        busy, done, err, hd_write_flag, mem_we;
  logic [31:0] hd_address, hd_wdata, hd_rdata, mem_wdata, mem_rdata;
  logic [14:0] mem_address;

  hd_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .proc_id(proc_id),
    .disk_base(disk_base), .length(length), .busy(busy), .done(done), .err(err),
    .hd_address(hd_address), .hd_write_flag(hd_write_flag), .hd_wdata(hd_wdata),
    .hd_rdata(hd_rdata), .mem_address(mem_address), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem  [0:32767];
  logic [31:0] disk [0:4095];
  logic        seeded = 1'b0;
  int          cyc = 0;

  // Synchronous-read memory and disk models, contents randomised on the first edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!seeded) begin
      for (int i = 0; i < 32768; i++) mem[i] <= $urandom;
      for (int i = 0; i < 4096; i++)  disk[i] <= $urandom;
      seeded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_address] <= mem_wdata;
      if (hd_write_flag && hd_address < 32'd4096) disk[hd_address[11:0]] <= hd_wdata;
    end
    mem_rdata <= mem[mem_address];
    hd_rdata  <= disk[hd_address[11:0]];
  end

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, errors = 0;
  int  bs = 1, be = 0;

  function automatic string kn(input int k);
    case (k)
      K_MW:   return "mem_write";
      K_HW:   return "disk_write";
      K_DONE: return "done";
      default: return "err";
    endcase
  endfunction

  task automatic chk(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s cyc=%0d addr=%h data=%h", kn(k), cyc, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d || e.cyc != cyc)
        begin
          errors++;
          $display("FAIL event got %s@%0d a=%h d=%h want %s@%0d a=%h d=%h",
                   kn(k), cyc, a, d, kn(e.kind), e.cyc, e.addr, e.data);
        end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we)        chk(K_MW, 32'(mem_address), mem_wdata);
      if (hd_write_flag) chk(K_HW, hd_address, hd_wdata);
      if (done)          chk(K_DONE, 32'd0, 32'd0);
      if (err)           chk(K_ERR, 32'd0, 32'd0);
      checks++;
      if (busy !== (cyc >= bs && cyc <= be)) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, (cyc >= bs && cyc <= be));
      end
    end
  end

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] d, input int c);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Reference: a legal command of L words produces write i in cycle i+2 and done in
  // cycle L+2 (cycle 1 is the one right after the accepting edge, at cyc == c0).
  task automatic issue(input logic d, input int p, input int b, input int len, output int w);
    int     c0;
    longint last;
    int     mb;
    @(negedge clk);
    dir = d; proc_id = 4'(p); disk_base = 32'(b); length = 12'(len); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0   = cyc;
    last = longint'(b) + longint'(len);
    mb   = p * 2048;
    w    = 0;
    if (len > 2048 || last > 4096) push(K_ERR, 0, 0, c0);
    else if (len == 0) push(K_DONE, 0, 0, c0);
    else begin
      for (int i = 0; i < len; i++)
        if (!d) push(K_MW, 32'(mb + i), disk[b + i], c0 + i + 1);
        else    push(K_HW, 32'(b + i), mem[mb + i], c0 + i + 1);
      push(K_DONE, 0, 0, c0 + len + 1);
      bs = c0; be = c0 + len;
      w  = len;
    end
  endtask

  task automatic finish_cmd(input int w, input string name);
    repeat (w + 4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_events got %0d want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic outs_zero(input string name);
    checks++;
    if ({busy, done, err, hd_address, hd_write_flag, hd_wdata, mem_address, mem_we, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL %s outputs got busy=%b done=%b err=%b hda=%h hdw=%b ma=%h mwe=%b want all 0",
               name, busy, done, err, hd_address, hd_write_flag, mem_address, mem_we);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w, d, p, b, len, sel;
    logic [31:0] snap;
    repeat (3) @(negedge clk);
    outs_zero("reset");
    rst_n = 1'b1;

    issue(1'b0, 2, 0, 4, w);     finish_cmd(w, "load4");
    issue(1'b1, 1, 3000, 3, w);  finish_cmd(w, "store3");
    issue(1'b0, 0, 0, 2049, w);  finish_cmd(w, "len_oob");
    issue(1'b1, 3, 4090, 10, w); finish_cmd(w, "disk_oob");
    issue(1'b0, 4, 4096, 0, w);  finish_cmd(w, "len0");
    issue(1'b0, 15, 1000, 2048, w); finish_cmd(w, "full_region");

    issue(1'b0, 5, 100, 10, w);
    repeat (3) @(negedge clk);
    dir = 1'b1; proc_id = 4'd9; disk_base = 32'd7; length = 12'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_cmd(w, "restart_ignored");

    // Reset lands in cycle 3 of an 8-word LOAD: only word 0 may be written.
    snap = mem[3 * 2048 + 1];
    issue(1'b0, 3, 200, 8, w);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    outs_zero("async_reset");
    checks++;
    if (exp_q.size() != 8) begin
      errors++;
      $display("FAIL reset_words_written got %0d want 1", 9 - exp_q.size());
    end
    exp_q.delete();
    bs = 1; be = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem[3 * 2048 + 1] !== snap) begin
      errors++;
      $display("FAIL reset_word1 got %h want %h", mem[3 * 2048 + 1], snap);
    end
    issue(1'b0, 3, 200, 8, w); finish_cmd(w, "after_reset");

    for (int n = 0; n < 24; n++) begin
      d   = int'($urandom_range(0, 1));
      p   = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      len = 0;
      else if (sel == 1) len = int'($urandom_range(2049, 4095));
      else               len = int'($urandom_range(1, 40));
      if (sel == 1)      b = int'($urandom_range(0, 4095));
      else if (sel == 2) b = int'($urandom_range(4060, 4096));
      else               b = int'($urandom_range(0, 4096 - len));
      issue(d[0], p, b, len, w);
      finish_cmd(w, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
